// File: rtl/serial_adder.sv
// Bit-serial adder. Operands are captured in parallel and then added LSB-first,
// one bit per clock, through a single full adder built from two half adders
// and an OR gate. The result is published only when the final bit completes.

// Half-adder primitive: sum is the XOR, carry is the AND of the two inputs.
module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic carry_o
);

    assign sum_o   = a_i ^ b_i;
    assign carry_o = a_i & b_i;

endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    // Bit counter wide enough to index WIDTH-1; WIDTH >= 2 keeps this >= 1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] s_sh_q, s_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;

    // Full adder datapath: first half adder combines the operand bits, the
    // second folds in the running carry; either half adder's carry propagates.
    logic ha0_sum, ha0_carry;
    logic ha1_sum, ha1_carry;
    logic fa_bit, fa_carry;

    half_adder u_ha0 (
        .a_i     (a_sh_q[0]),
        .b_i     (b_sh_q[0]),
        .sum_o   (ha0_sum),
        .carry_o (ha0_carry)
    );

    half_adder u_ha1 (
        .a_i     (ha0_sum),
        .b_i     (carry_q),
        .sum_o   (ha1_sum),
        .carry_o (ha1_carry)
    );

    assign fa_bit   = ha1_sum;
    assign fa_carry = ha0_carry | ha1_carry;

    // Result shift register after this bit lands in the MSB; on the last bit
    // this is the completed sum.
    logic [WIDTH-1:0] s_shifted;
    assign s_shifted = {fa_bit, s_sh_q[WIDTH-1:1]};

    // Next-state and datapath control; every register holds unless updated.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    a_sh_d  = a_i;
                    b_sh_d  = b_i;
                    carry_d = cin_i;
                    s_sh_d  = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                carry_d = fa_carry;
                s_sh_d  = s_shifted;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // Publish only the finished result; outputs never see
                    // a partially shifted sum.
                    sum_d   = s_shifted;
                    cout_d  = fa_carry;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                // Start requests here are dropped; a new add begins from IDLE.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any add in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = (state_q == S_RUN);
    assign done_o = done_q;
    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8). Expected {cout,sum} values
// are pushed to a scoreboard queue when an add is issued and popped on done.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    logic [W:0]   exp_q[$];
    int           n_vec;
    int           n_err;

    serial_adder #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .a_i     (a),
        .b_i     (b),
        .cin_i   (cin),
        .busy_o  (busy),
        .done_o  (done),
        .sum_o   (sum),
        .cout_o  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one add request and record its expected result.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        @(negedge clk);
        a     = av;
        b     = bv;
        cin   = cv;
        start = 1'b1;
        exp_q.push_back(9'(av) + 9'(bv) + 9'(cv));
        @(negedge clk);
        start = 1'b0;
        // Operands are don't-care after capture; scramble them.
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom);
    endtask

    // Wait (bounded) for done, counting edges after the accepting edge and
    // the number of sampled cycles with busy high.
    task automatic wait_done(output int edges, output int busy_cycles, output bit timed_out);
        edges = 0;
        busy_cycles = 0;
        while (done !== 1'b1 && edges < 40) begin
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
            edges++;
        end
        timed_out = (done !== 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({busy, done, cout, sum} !== '0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b done=%b cout=%b sum=%h, required all 0", busy, done, cout, sum);
        end
        rst = 1'b0;
        $display("reset: busy=%b done=%b cout=%b sum=%h", busy, done, cout, sum);
    endtask

    task automatic test_add(input string name, input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        int edges, bc; bit to; logic [W:0] e; logic [W-1:0] held;
        issue(av, bv, cv);
        wait_done(edges, bc, to);
        n_vec++;
        if (to) begin
            n_err++;
            $display("FAIL %s_timeout: done never rose within 40 cycles", name);
            return;
        end
        e = exp_q.pop_front();
        if ({cout, sum} !== e) begin
            n_err++;
            $display("FAIL %s_result: got {cout,sum}=%h, required %h", name, {cout, sum}, e);
        end
        n_vec++;
        if (edges != W || bc != W) begin
            n_err++;
            $display("FAIL %s_latency: edges_to_done=%0d busy_cycles=%0d, required %0d/%0d", name, edges, bc, W, W);
        end
        held = sum;
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0 || sum !== held) begin
            n_err++;
            $display("FAIL %s_pulse: done=%b busy=%b sum=%h after done cycle, required 0/0/%h", name, done, busy, sum, held);
        end
        $display("%s: a=%h b=%h cin=%b -> cout=%b sum=%h (exp %h) edges=%0d", name, av, bv, cv, cout, sum, e, edges);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({busy, done, cout, sum} !== '0) begin
            n_err++;
            $display("FAIL async_reset: busy=%b done=%b cout=%b sum=%h before any edge, required all 0", busy, done, cout, sum);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("async_reset: cout=%b sum=%h", cout, sum);
    endtask

    task automatic test_start_ignored();
        int edges, extra; logic [W:0] e;
        issue(8'h3C, 8'h0F, 1'b0);
        edges = 0;
        while (done !== 1'b1 && edges < 40) begin
            if (edges == 2) begin a = 8'hFF; start = 1'b1; end
            if (edges == 3) start = 1'b0;
            @(negedge clk);
            edges++;
        end
        start = 1'b0;
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL start_ignored_timeout: no done within 40 cycles");
            return;
        end
        e = exp_q.pop_front();
        if ({cout, sum} !== e) begin
            n_err++;
            $display("FAIL start_ignored_result: got %h, required %h", {cout, sum}, e);
        end
        extra = 0;
        repeat (14) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        n_vec++;
        if (extra != 0) begin
            n_err++;
            $display("FAIL start_ignored_single: %0d extra done pulses, required 0", extra);
        end
        $display("start_ignored: cout=%b sum=%h (exp %h) extra_done=%0d", cout, sum, e, extra);
    endtask

    task automatic test_abort();
        int seen;
        @(negedge clk);
        a = 8'h7F; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({busy, done, cout, sum} !== '0) begin
            n_err++;
            $display("FAIL abort_outputs: busy=%b done=%b cout=%b sum=%h, required all 0", busy, done, cout, sum);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (14) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        n_vec++;
        if (seen != 0 || sum !== '0) begin
            n_err++;
            $display("FAIL abort_quiet: %0d busy/done cycles, sum=%h after abort, required 0 and 00", seen, sum);
        end
        $display("abort: sum=%h cout=%b activity=%0d", sum, cout, seen);
        test_add("restart", 8'h7F, 8'h01, 1'b0);
    endtask

    task automatic test_back_to_back();
        int edges; logic [W:0] e; logic [W-1:0] av, bv; logic cv;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            av = W'($urandom); bv = W'($urandom); cv = 1'($urandom);
            a = av; b = bv; cin = cv; start = 1'b1;
            exp_q.push_back(9'(av) + 9'(bv) + 9'(cv));
            edges = 0;
            do begin
                @(negedge clk);
                edges++;
            end while (done !== 1'b1 && edges < 40);
            n_vec++;
            if (done !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_timeout: op %0d no done", i);
                start = 1'b0;
                return;
            end
            e = exp_q.pop_front();
            if ({cout, sum} !== e) begin
                n_err++;
                $display("FAIL b2b_result: op %0d got %h, required %h", i, {cout, sum}, e);
            end
            n_vec++;
            if (edges != ((i == 0) ? W + 1 : W + 2)) begin
                n_err++;
                $display("FAIL b2b_spacing: op %0d edges=%0d, required %0d", i, edges, (i == 0) ? W + 1 : W + 2);
            end
            $display("b2b %0d: a=%h b=%h cin=%b -> %h (exp %h) edges=%0d", i, av, bv, cv, {cout, sum}, e, edges);
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_add("zero", 8'h00, 8'h00, 1'b0);
        test_add("ripple", 8'hFF, 8'h01, 1'b0);
        test_async_reset();
        test_add("alternating", 8'hA5, 8'h5A, 1'b1);
        test_start_ignored();
        test_abort();
        test_back_to_back();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
